// File: rtl/inst_loader.sv
// inst_loader: parses a framed program image from a byte stream (length,
// little-endian words, XOR checksum), writes each word into instruction
// memory, and holds the core in reset until a verified load completes.
module inst_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [31:0]       word_q, word_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic              is_busy;
    logic [16:0]       n_full;

    assign xfer    = in_valid & in_ready_q;
    assign is_busy = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA) ||
                     (state_q == S_WRITE) || (state_q == S_CHK);
    assign n_full  = {1'b0, in_data, len_q[7:0]};

    // Next-state, datapath updates and registered output decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        chk_d       = chk_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    chk_d      = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (n_full > MAX_N)      state_d = S_ERR;
                    else if (n_full == '0)   state_d = S_CHK;
                    else                     state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d[8*byte_idx_q +: 8] = in_data;
                    chk_d      = chk_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // The write strobe is registered here so it shows up
                        // in the cycle spent in WRITE.
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_W-1:0];
                        mem_wdata_d = word_d;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == len_q) state_d = S_CHK;
                else                               state_d = S_DATA;
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) state_d = S_DONE;
                    else                  state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats any byte transfer or pending write in the same cycle.
        if (abort && is_busy) begin
            state_d     = S_IDLE;
            mem_we_d    = 1'b0;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end

        in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
        busy_d     = in_ready_d || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        core_rst_d = (state_d != S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            chk_q       <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            chk_q       <= chk_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory read port: loads a program image into instruction memory from a byte stream (valid/ready) before the single-cycle core fetches from it.
- Parses a framed image (length, little-endian instruction words, XOR checksum) and issues one word write per instruction.
- Holds the core in reset via core_rst until the load completes and the checksum is verified.

Parameters:
- ADDR_W, 8, word-address width; matches the PC[9:2] fetch index.
- MAX_WORDS, 256, maximum image length in words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load when not busy
- abort  input  1  synchronous; cancels an in-progress load
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  instruction word
- core_rst  output  1  core reset request; high unless the state is DONE
- busy  output  1  high in LEN0, LEN1, DATA, WRITE and CHK
- done  output  1  load finished with checksum OK; held until the next start
- err  output  1  load failed; held until the next start

Behaviour:
- All outputs are registered.
- Reset values: core_rst=1; all other outputs 0; state=IDLE; counters and checksum cleared.
- Frame format, in this byte order:
  - LEN_LO, LEN_HI: N, a 16-bit little-endian word count.
  - N*4 data bytes, each word least-significant byte first.
  - CHK: the XOR of all data bytes. Length bytes are excluded from the checksum.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR.
  - IDLE/DONE/ERR + start -> LEN0. On this transition: clear done, err, word index, byte index and checksum; set core_rst=1.
  - LEN0: accept byte -> N[7:0]; go to LEN1.
  - LEN1: accept byte -> N[15:8].
    - N > MAX_WORDS -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: each accepted byte is shifted into the word at lane byte_idx and XORed into the checksum. byte_idx counts 0..3; on the 4th byte go to WRITE.
  - WRITE: for exactly one cycle, mem_we=1, mem_addr=word_idx, mem_wdata=assembled word.
    - Next cycle: word_idx+1.
    - If word_idx+1 == N -> CHK, else -> DATA.
  - CHK: accept byte.
    - Byte equals running XOR -> DONE.
    - Otherwise -> ERR.
  - DONE: done=1, core_rst=0.
  - ERR: err=1, core_rst=1.
- in_ready=1 only in LEN0, LEN1, DATA and CHK. in_ready=0 in IDLE, WRITE, DONE and ERR, so at most one byte in four consecutive data bytes is stalled.
- Write latency: the 4th byte of a word accepted at cycle t gives mem_we high at cycle t+1.
- mem_we is never asserted outside WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- start while busy is ignored.
- abort while busy -> IDLE at the next edge. mem_we is forced 0 that cycle, core_rst stays 1, and done and err stay 0.
- abort has priority over a simultaneous byte transfer.
- abort in IDLE/DONE/ERR is ignored.
- start and abort in the same cycle while busy: abort wins.
- start and abort in the same cycle while not busy: start wins.
- Asynchronous rst mid-load returns to IDLE immediately with reset values. Words already written stay in memory; the loader does not clear them.
- word_idx never wraps: N <= MAX_WORDS is checked before any write.

Test Plan:
- Basic load: start, then bytes 02 00 93 00 50 00 13 01 A0 00 71.
  - Required: mem_we pulses twice, addr0=0x00500093 and addr1=0x00A00113.
  - Then done=1, core_rst=0, err=0.
- Bad checksum: same frame with checksum 0x70.
  - Required: both writes occur, then err=1, done=0, core_rst=1.
- Zero length: bytes 00 00 00.
  - Required: no mem_we, done=1.
  - Bytes 00 00 05 -> err=1.
- Oversize: N=0x0101 (257) with MAX_WORDS=256.
  - Required: err=1 immediately after LEN_HI, no mem_we, in_ready=0.
- Backpressure and timing: hold in_valid=1 continuously.
  - Required: in_ready drops for exactly one cycle after each 4th data byte.
  - mem_we appears one cycle after the 4th byte is accepted.
  - Randomly gapped in_valid gives identical memory contents.
- Abort/reset: abort after 6 data bytes -> IDLE, done=err=0, core_rst=1, only word 0 written. A subsequent start plus a full frame -> done=1. Asserting rst mid-DATA -> outputs return to reset values asynchronously, without waiting for a clock edge.
